// File: rtl/fetch_queue_mp.sv
// Multi-ported fetch queue. Up to ENQ_WIDTH entries go in per cycle, packed
// together with gaps in the mask removed. The DEQ_WIDTH oldest entries are
// always visible, and deq_count of them are retired per cycle.

// One read lane: shows slot head+LANE when the queue holds more than LANE entries.
module fetch_queue_mp_rd_lane #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 65,
  parameter int LANE   = 0
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH):0]       count,
  output logic                         valid,
  output logic [DATA_W-1:0]            data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  assign valid = count > CW'(LANE);
  // Head plus lane wraps naturally because DEPTH is a power of two.
  assign data  = valid ? mem[head + PW'(LANE)] : '0;
endmodule

module fetch_queue_mp #(
  parameter int ENQ_WIDTH = 3,
  parameter int DEQ_WIDTH = 3,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 65,
  parameter int AF_THRESH = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [ENQ_WIDTH-1:0]                 enq_valid,
  input  logic [ENQ_WIDTH-1:0][DATA_W-1:0]     enq_data,
  output logic                                 enq_ready,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]       deq_count,
  output logic [DEQ_WIDTH-1:0]                 deq_valid,
  output logic [DEQ_WIDTH-1:0][DATA_W-1:0]     deq_data,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic [31:0]                          stall_cycles,
  output logic                                 err_underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [PW-1:0]                 head, tail;
  logic [CW-1:0]                 deq_req, eff, enq_num;
  logic [ENQ_WIDTH-1:0][PW-1:0]  lane_off;
  logic                          underflow;

  // enq_ready depends only on the registered count, so a producer never
  // sees a combinational path from the consumer's deq_count.
  assign enq_ready   = count <= CW'(DEPTH - ENQ_WIDTH);
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign almost_full = count >= CW'(AF_THRESH);

  assign deq_req   = CW'(deq_count);
  assign underflow = deq_req > count;
  assign eff       = underflow ? count : deq_req;

  // Prefix popcount of the enqueue mask: each set lane lands at tail plus
  // the number of set lanes below it, so gaps in the mask use no slots.
  always_comb begin
    enq_num  = '0;
    lane_off = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      lane_off[i] = enq_num[PW-1:0];
      enq_num     = enq_num + CW'(enq_valid[i]);
    end
  end

  // Storage write. Reset and flush do not clear entries; they only move pointers.
  always_ff @(posedge clk) begin
    if (!rst && enq_ready && !flush) begin
      for (int i = 0; i < ENQ_WIDTH; i++)
        if (enq_valid[i]) mem[tail + lane_off[i]] <= enq_data[i];
    end
  end

  // Pointers and occupancy. Flush overrides same-cycle enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + eff[PW-1:0];
      tail  <= tail + (enq_ready ? enq_num[PW-1:0] : '0);
      count <= count - eff + (enq_ready ? enq_num : '0);
    end
  end

  // Backpressure counter (saturating) and sticky underflow flag. Flush does not affect these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (|enq_valid && !enq_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (underflow)
        err_underflow <= 1'b1;
    end
  end

  // Read lanes: one instance per dequeue port.
  for (genvar j = 0; j < DEQ_WIDTH; j++) begin : g_rd
    fetch_queue_mp_rd_lane #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LANE(j)) u_rd (
      .mem   (mem),
      .head  (head),
      .count (count),
      .valid (deq_valid[j]),
      .data  (deq_data[j])
    );
  end
endmodule

// File: doc/fetch_queue_mp.md
FETCH_QUEUE_MP -- requirements
Module: fetch_queue_mp

Interface
REQ-001 SHALL have parameter ENQ_WIDTH, default 3: enqueue lanes per cycle.
REQ-002 SHALL have parameter DEQ_WIDTH, default 3: dequeue lanes per cycle.
REQ-003 SHALL have parameter DEPTH, default 16: entries; power of 2, >= max(ENQ_WIDTH, DEQ_WIDTH).
REQ-004 SHALL have parameter DATA_W, default 65: payload width ({valid, pc[31:0], instruction[31:0]} fetch entry).
REQ-005 SHALL have parameter AF_THRESH, default 12: almost-full level.
REQ-006 SHALL have port clk  in  1: clock, rising edge.
REQ-007 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-008 SHALL have port flush  in  1: synchronous queue clear.
REQ-009 SHALL have port enq_valid  in  ENQ_WIDTH: per-lane enqueue request; any bit pattern is legal.
REQ-010 SHALL have port enq_data  in  ENQ_WIDTH x DATA_W: per-lane payload.
REQ-011 SHALL have port enq_ready  out  1: whole enqueue group accepted this cycle.
REQ-012 SHALL have port deq_count  in  clog2(DEQ_WIDTH+1): number of head entries consumed this cycle.
REQ-013 SHALL have port deq_valid  out  DEQ_WIDTH: lane j holds entry head+j.
REQ-014 SHALL have port deq_data  out  DEQ_WIDTH x DATA_W: entries head..head+DEQ_WIDTH-1.
REQ-015 SHALL have port count  out  clog2(DEPTH)+1: occupancy.
REQ-016 SHALL have port full, empty, almost_full  out  1 each: status flags.
REQ-017 SHALL have port stall_cycles  out  32: count of cycles with any enq_valid and !enq_ready.
REQ-018 SHALL have port err_underflow  out  1: sticky; set when deq_count > count.

Function
REQ-019 SHALL drive enq_ready = (DEPTH - count) >= ENQ_WIDTH, from registered count only; no combinational path from deq_count.
REQ-020 SHALL, when enq_ready=1, write all set enq_valid lanes compacted into consecutive slots from tail, preserving lane order (lane 0 first); gaps in the mask consume no slots.
REQ-021 SHALL, when enq_ready=0, accept no lane; the producer holds the group.
REQ-022 SHALL remove eff = min(deq_count, count) entries from head per cycle.
REQ-023 SHALL set err_underflow when deq_count > count; it stays set until reset.
REQ-024 SHALL update count_next = count - eff + popcount(enq_valid) when enq_ready=1, else count - eff; enqueue and dequeue in the same cycle are both honoured.
REQ-025 SHALL wrap head and tail modulo DEPTH; deq_data lane j reads slot (head+j) mod DEPTH.
REQ-026 SHALL drive deq_valid[j] = (count > j) and deq_data[j] = 0 when deq_valid[j] = 0.
REQ-027 SHALL make an entry written at edge N visible on deq_data from edge N onward (one-cycle enqueue-to-dequeue latency); no bypass from enq_data.
REQ-028 SHALL drive full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_THRESH), all combinational from count.
REQ-029 SHALL, on flush, set head = tail = count = 0 at the next edge; flush overrides same-cycle enqueue and dequeue; stall_cycles and err_underflow are unaffected.
REQ-030 SHALL saturate stall_cycles at 32'hFFFF_FFFF.
REQ-031 SHALL leave storage contents unchanged by rst and flush; only pointers are cleared.

Reset
REQ-032 SHALL, on rst assertion, immediately and asynchronously clear head, tail, count, stall_cycles and err_underflow, giving count=0, empty=1, full=0, almost_full=0, enq_ready=1, deq_valid=0, deq_data=0.
REQ-033 SHALL hold the reset state while rst=1 and resume operation on the first edge after deassertion; rst asserted mid-operation discards all entries.

Verification
REQ-034 SHALL cover sparse compaction: enq_valid=3'b101 with data A,_,C, deq_count=0 -> next cycle count=2, deq_data[0]=A, deq_data[1]=C, deq_valid=3'b011.
REQ-035 SHALL cover fill and backpressure: 5 full groups of 3 -> count=15, enq_ready=0, almost_full=1; hold enq_valid=3'b111 for 4 cycles -> stall_cycles=4, count stays 15.
REQ-036 SHALL cover wrap-around: alternate enqueue of 3 and deq_count=3 for 20 cycles -> FIFO order preserved across slot 15->0, count stays constant.
REQ-037 SHALL cover simultaneous operations: count=13, enq 3 lanes, deq_count=2 -> count=14; enq_ready is 1 in that cycle (16-13 >= 3).
REQ-038 SHALL cover underflow: count=1, deq_count=3 -> count=0 and err_underflow=1 (sticky); then flush with enq_valid=3'b111 -> count=0, err_underflow still 1.
REQ-039 SHALL cover async reset mid-burst: rst pulsed between edges at count=9 -> count=0 and empty=1 before the next edge, stall_cycles=0.
